key_conditioner: RTL and testbench

- Input stage directly upstream of the game control block. Converts raw, bouncy, asynchronous, active-low board keys into clean synchronous commands: right, left, jump, squat, attack, defend, select.
- Movement and shield commands are debounced levels. Jump, attack and select are single-cycle pulses.
- Gameplay commands are gated by the game control block's "is gaming" flag, so stray presses outside play are discarded.

---
 rtl/key_conditioner_pkg.sv | 24 ++
 rtl/key_debounce.sv | 59 +++++
 rtl/key_conditioner.sv | 108 ++++++++++
 tb/tb_key_conditioner.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_conditioner_pkg.sv
// Shared constants for the key conditioner: key bit positions and a
// helper that sizes the debounce counter.
package key_conditioner_pkg;

  localparam int N_BTN      = 7;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_JUMP   = 2;
  localparam int BTN_SQUAT  = 3;
  localparam int BTN_ATTACK = 4;
  localparam int BTN_DEFEND = 5;
  localparam int BTN_SELECT = 6;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n < 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: active-low raw input -> 2-flop synchroniser -> debounce counter
// -> stable level, plus a one-cycle flag on the press edge of the stable level.
module key_debounce
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_stable,
  output logic o_rise
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             rise;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous key into the clock domain, inverted to active-high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ~i_btn_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from the stable value for
  // DEBOUNCE_CYCLES consecutive samples; any return to equality restarts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable <= 1'b0;
      rise   <= 1'b0;
      cnt    <= '0;
    end else begin
      rise <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        rise   <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign o_stable = stable;
  assign o_rise   = rise;

endmodule

// File: rtl/key_conditioner.sv
// Key conditioner: turns seven raw, bouncy, active-low board keys into clean
// synchronous game commands. Movement and shield are debounced levels; jump,
// attack and select are single-cycle pulses. Everything except select is
// gated by i_is_gaming in the output register.
//
// Optional build macro KEY_AUTOREPEAT_EN: while attack stays held during
// play, extra attack pulses follow REPEAT_DELAY cycles after the press pulse
// and then every REPEAT_PERIOD cycles. Without the macro there is exactly one
// attack pulse per press and no repeat counter exists.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] i_btn_n,
  input  logic             i_is_gaming,
  output logic             o_right,
  output logic             o_left,
  output logic             o_jump,
  output logic             o_squat,
  output logic             o_attack,
  output logic             o_defend,
  output logic             o_select
);

  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] rise;
  logic             rep_fire;

  for (genvar k = 0; k < N_BTN; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn_n (i_btn_n[k]),
      .o_stable(stable[k]),
      .o_rise  (rise[k])
    );
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_phase;   // 0: waiting for the first repeat, 1: periodic
  logic             rep_run;

  assign rep_run  = stable[BTN_ATTACK] & i_is_gaming;
  assign rep_fire = rep_run &
                    (rep_phase ? (rep_cnt == REP_W'(REPEAT_PERIOD))
                               : (rep_cnt == REP_W'(REPEAT_DELAY)));

  // Count held-and-playing cycles; restart the period after every repeat
  // pulse and clear on release or when play stops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (!rep_run) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= REP_W'(1);
      rep_phase <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt + REP_W'(1);
      rep_phase <= rep_phase;
    end
  end
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
  assign rep_fire = 1'b0;
`endif

  // Stable levels and edges that no command consumes in this build.
  logic unused_key_bits;
  assign unused_key_bits = ^{stable[BTN_JUMP], stable[BTN_SELECT], stable[BTN_ATTACK],
                             rise[BTN_RIGHT], rise[BTN_LEFT], rise[BTN_SQUAT],
                             rise[BTN_DEFEND]};

  // Output register: gating, right/left cancel, squat beats jump.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_right  <= 1'b0;
      o_left   <= 1'b0;
      o_jump   <= 1'b0;
      o_squat  <= 1'b0;
      o_attack <= 1'b0;
      o_defend <= 1'b0;
      o_select <= 1'b0;
    end else begin
      o_right  <= i_is_gaming & stable[BTN_RIGHT] & ~stable[BTN_LEFT];
      o_left   <= i_is_gaming & stable[BTN_LEFT]  & ~stable[BTN_RIGHT];
      o_jump   <= i_is_gaming & rise[BTN_JUMP]    & ~stable[BTN_SQUAT];
      o_squat  <= i_is_gaming & stable[BTN_SQUAT];
      o_attack <= i_is_gaming & (rise[BTN_ATTACK] | rep_fire);
      o_defend <= i_is_gaming & stable[BTN_DEFEND];
      o_select <= rise[BTN_SELECT];
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with DEBOUNCE_CYCLES=4: directed
// scenarios with hand-computed edge numbers, then randomized keys, bounce,
// gaming toggles and resets checked every cycle against a behavioural model.
module tb_key_conditioner;
  import key_conditioner_pkg::*;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_BTN-1:0] i_btn_n = 7'h7F;
  logic             i_is_gaming = 1'b0;
  logic o_right, o_left, o_jump, o_squat, o_attack, o_defend, o_select;

  key_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_btn_n    (i_btn_n),
    .i_is_gaming(i_is_gaming),
    .o_right    (o_right),
    .o_left     (o_left),
    .o_jump     (o_jump),
    .o_squat    (o_squat),
    .o_attack   (o_attack),
    .o_defend   (o_defend),
    .o_select   (o_select)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;

  // Behavioural model state: two-sample delay line, accepted level, how many
  // consecutive samples disagreed with it, and whether it was just pressed.
  bit m_s1     [N_BTN];
  bit m_s2     [N_BTN];
  bit m_stable [N_BTN];
  bit m_pressed[N_BTN];
  int m_disagree[N_BTN];
  int m_held = 0;   // consecutive cycles attack has been held during play

  // Observations used by the directed checks.
  int cnt_attack = 0;
  int cnt_jump = 0;
  int cnt_select = 0;
  int right_rise_edge = -1;
  int defend_rise_edge = -1;
  int attack_edges[$];
  bit prev_right = 1'b0;
  bit prev_defend = 1'b0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_cnt, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, act, exp);
    end
  endtask

  // Model update and per-cycle comparison against the DUT.
  always @(posedge clk) begin : p_check
    bit e_right, e_left, e_jump, e_squat, e_attack, e_defend, e_select;
    bit g, fire, old_attack;
    g = i_is_gaming;
    fire = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    fire = g && m_stable[BTN_ATTACK] && (m_held >= RD) && (((m_held - RD) % RP) == 0);
`endif
    if (!rst_n) begin
      {e_right, e_left, e_jump, e_squat, e_attack, e_defend, e_select} = 7'b0000000;
    end else begin
      e_right  = g && m_stable[BTN_RIGHT] && !m_stable[BTN_LEFT];
      e_left   = g && m_stable[BTN_LEFT] && !m_stable[BTN_RIGHT];
      e_jump   = g && m_pressed[BTN_JUMP] && !m_stable[BTN_SQUAT];
      e_squat  = g && m_stable[BTN_SQUAT];
      e_attack = g && (m_pressed[BTN_ATTACK] || fire);
      e_defend = g && m_stable[BTN_DEFEND];
      e_select = m_pressed[BTN_SELECT];
    end

    old_attack = m_stable[BTN_ATTACK];
    if (!rst_n) begin
      for (int k = 0; k < N_BTN; k++) begin
        m_s1[k] = 1'b0; m_s2[k] = 1'b0; m_stable[k] = 1'b0;
        m_pressed[k] = 1'b0; m_disagree[k] = 0;
      end
      m_held = 0;
    end else begin
      m_held = (old_attack && g) ? m_held + 1 : 0;
      for (int k = 0; k < N_BTN; k++) begin
        m_pressed[k] = 1'b0;
        if (m_s2[k] != m_stable[k]) begin
          m_disagree[k]++;
          if (m_disagree[k] == DB) begin
            m_stable[k]   = m_s2[k];
            m_pressed[k]  = m_s2[k];
            m_disagree[k] = 0;
          end
        end else begin
          m_disagree[k] = 0;
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = !i_btn_n[k];
      end
    end
    edge_cnt++;

    #1;
    check_bit("right",  o_right,  e_right);
    check_bit("left",   o_left,   e_left);
    check_bit("jump",   o_jump,   e_jump);
    check_bit("squat",  o_squat,  e_squat);
    check_bit("attack", o_attack, e_attack);
    check_bit("defend", o_defend, e_defend);
    check_bit("select", o_select, e_select);

    if (o_attack) begin
      cnt_attack++;
      attack_edges.push_back(edge_cnt);
    end
    if (o_jump) cnt_jump++;
    if (o_select) cnt_select++;
    if (o_right && !prev_right) right_rise_edge = edge_cnt;
    if (o_defend && !prev_defend) defend_rise_edge = edge_cnt;
    prev_right = o_right;
    prev_defend = o_defend;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check_int(name, int'({o_right, o_left, o_jump, o_squat, o_attack, o_defend, o_select}), 0);
  endtask

  logic [N_BTN-1:0] base_btn;
  logic [N_BTN-1:0] glitch;
  int base;
  int exp_rep[5];

  initial begin
    exp_rep[0] = 7; exp_rep[1] = 15; exp_rep[2] = 20; exp_rep[3] = 25; exp_rep[4] = 30;

    // Reset state
    cyc(3);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    cyc(2);

    // 1. Clean attack press: pulse on edge 7
    i_is_gaming = 1'b1;
    cyc(12);
    cnt_attack = 0;
    attack_edges.delete();
    base = edge_cnt;
    i_btn_n[BTN_ATTACK] = 1'b0;
    cyc(20);
`ifdef KEY_AUTOREPEAT_EN
    check_int("t1_attack_count", cnt_attack, 2);
`else
    check_int("t1_attack_count", cnt_attack, 1);
`endif
    check_int("t1_attack_edge", attack_edges[0] - base, 7);
    i_btn_n[BTN_ATTACK] = 1'b1;
    cyc(12);

    // 2. Bounce rejected, then a solid hold gives one pulse
    cnt_jump = 0;
    i_btn_n[BTN_JUMP] = 1'b0; cyc(3);
    i_btn_n[BTN_JUMP] = 1'b1; cyc(1);
    i_btn_n[BTN_JUMP] = 1'b0; cyc(3);
    i_btn_n[BTN_JUMP] = 1'b1; cyc(12);
    check_int("t2_bounce_jump", cnt_jump, 0);
    i_btn_n[BTN_JUMP] = 1'b0; cyc(10);
    check_int("t2_hold_jump", cnt_jump, 1);
    i_btn_n[BTN_JUMP] = 1'b1; cyc(12);

    // 3. Gating: select passes, right waits for play
    i_is_gaming = 1'b0;
    cnt_select = 0;
    i_btn_n[BTN_RIGHT] = 1'b0;
    i_btn_n[BTN_SELECT] = 1'b0;
    cyc(12);
    check_int("t3_select_count", cnt_select, 1);
    check_bit("t3_right_gated", o_right, 1'b0);
    i_is_gaming = 1'b1;
    @(posedge clk);
    #2;
    check_bit("t3_right_on_play", o_right, 1'b1);
    i_btn_n[BTN_RIGHT] = 1'b1;
    i_btn_n[BTN_SELECT] = 1'b1;
    cyc(12);

    // 4. Right/left conflict, then release left
    i_btn_n[BTN_RIGHT] = 1'b0;
    i_btn_n[BTN_LEFT] = 1'b0;
    cyc(12);
    check_bit("t4_right_conflict", o_right, 1'b0);
    check_bit("t4_left_conflict", o_left, 1'b0);
    right_rise_edge = -1;
    base = edge_cnt;
    i_btn_n[BTN_LEFT] = 1'b1;
    cyc(10);
    check_int("t4_right_latency", right_rise_edge - base, 7);
    i_btn_n[BTN_RIGHT] = 1'b1;
    cyc(12);

    // 5. Reset mid-operation
    i_btn_n[BTN_DEFEND] = 1'b0;
    cyc(10);
    check_bit("t5_defend_held", o_defend, 1'b1);
    rst_n = 1'b0;
    cyc(1);
    check_all_zero("t5_reset_clears");
    rst_n = 1'b1;
    defend_rise_edge = -1;
    base = edge_cnt;
    cyc(10);
    check_int("t5_defend_relatency", defend_rise_edge - base, 7);
    i_btn_n[BTN_DEFEND] = 1'b1;
    cyc(12);

`ifdef KEY_AUTOREPEAT_EN
    // 6. Auto-repeat: pulses on edges 7, 15, 20, 25, 30
    attack_edges.delete();
    base = edge_cnt;
    i_btn_n[BTN_ATTACK] = 1'b0;
    cyc(30);
    check_int("t6_repeat_count", attack_edges.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < attack_edges.size()) begin
        check_int("t6_repeat_edge", attack_edges[i] - base, exp_rep[i]);
      end
    end
    i_btn_n[BTN_ATTACK] = 1'b1;
    cyc(12);
`endif

    // Randomized phase: slow key changes, one-cycle glitches, play toggles,
    // rare resets; the per-cycle compare does the checking.
    base_btn = 7'h7F;
    repeat (4000) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        int idx;
        idx = $urandom_range(0, N_BTN - 1);
        base_btn[idx] = ~base_btn[idx];
      end
      glitch = '0;
      if ($urandom_range(0, 15) == 0) begin
        int gi;
        gi = $urandom_range(0, N_BTN - 1);
        glitch[gi] = 1'b1;
      end
      i_btn_n = base_btn ^ glitch;
      if ($urandom_range(0, 63) == 0) i_is_gaming = ~i_is_gaming;
      rst_n = ($urandom_range(0, 499) != 0);
    end
    rst_n = 1'b1;
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
